// File: rtl/hex_pkg.sv
// Shared constants for the seven-segment display controller.
// Latency: n/a (constants only).
// Backpressure: n/a.
package hex_pkg;

    // Register byte offsets from BASE.
    localparam logic [3:0] REG_DATA   = 4'h0;
    localparam logic [3:0] REG_BLANK  = 4'h4;
    localparam logic [3:0] REG_BLINK  = 4'h8;
    localparam logic [3:0] REG_PERIOD = 4'hC;

    // Active-low segment patterns, bit order g..a, indexed by nibble value.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

    // All segments off.
    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/hex_display_ctrl_if.sv
// Address/command half of the processor bus as seen by a bussed device.
// Latency: n/a (wires only).
// Backpressure: none; the bus has no wait states.
// Ports: address (bus address), wrtEn (1 = write cycle, 0 = read cycle).
interface hex_display_ctrl_if #(
    parameter int DBITS = 32
);
    logic [DBITS-1:0] address;
    logic             wrtEn;

    modport master (output address, output wrtEn);
    modport slave  (input  address, input  wrtEn);
endinterface

// File: rtl/hex_display_ctrl_seg7_decode.sv
// Hex nibble to active-low seven-segment glyph.
// Latency: combinational.
// Backpressure: none.
// Ports: nibble (4-bit value), seg (7-bit active-low, g..a).
module seg7_decode
    import hex_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    assign seg = SEG_TABLE[nibble];
endmodule

// File: rtl/hex_display_ctrl.sv
// Memory-mapped NDIGITS seven-segment controller with per-digit blank/blink.
// Latency: register write visible on hex_out one edge later; reads are combinational.
// Backpressure: none; every bus cycle completes immediately.
// Ports: clk, reset (sync, active-high), bus (address/wrtEn), dbus (shared
// tri-state data bus), hex_out (digit i at [7i+6:7i], active-low).
module hex_display_ctrl
    import hex_pkg::*;
#(
    parameter int                DBITS         = 32,
    parameter int                NDIGITS       = 4,
    parameter logic [DBITS-1:0]  BASE          = 32'hF000_0000,
    parameter int                CNT_W         = 26,
    parameter int unsigned       BLINK_DEFAULT = 25_000_000
) (
    input  logic                   clk,
    input  logic                   reset,
    hex_display_ctrl_if.slave      bus,
    inout  wire  [DBITS-1:0]       dbus,
    output logic [7*NDIGITS-1:0]   hex_out
);

    localparam logic [DBITS-1:0] ADDR_DATA   = BASE + DBITS'(REG_DATA);
    localparam logic [DBITS-1:0] ADDR_BLANK  = BASE + DBITS'(REG_BLANK);
    localparam logic [DBITS-1:0] ADDR_BLINK  = BASE + DBITS'(REG_BLINK);
    localparam logic [DBITS-1:0] ADDR_PERIOD = BASE + DBITS'(REG_PERIOD);

    logic [4*NDIGITS-1:0] data_r;
    logic [NDIGITS-1:0]   blank_r;
    logic [NDIGITS-1:0]   blink_r;
    logic [CNT_W-1:0]     period_r;
    logic [CNT_W-1:0]     cnt;
    logic                 phase;

    logic sel_data, sel_blank, sel_blink, sel_period, rd_en;
    logic [DBITS-1:0]     rd_data;
    logic [7*NDIGITS-1:0] hex_next;

    assign sel_data   = (bus.address == ADDR_DATA);
    assign sel_blank  = (bus.address == ADDR_BLANK);
    assign sel_blink  = (bus.address == ADDR_BLINK);
    assign sel_period = (bus.address == ADDR_PERIOD);
    assign rd_en      = !bus.wrtEn && (sel_data || sel_blank || sel_blink || sel_period);

    // Only the low bits of each write are stored; the rest of the bus is ignored.
    wire unused_dbus = ^dbus;

    always_comb begin
        rd_data = '0;
        if (sel_data)   rd_data[4*NDIGITS-1:0] = data_r;
        if (sel_blank)  rd_data[NDIGITS-1:0]   = blank_r;
        if (sel_blink)  rd_data[NDIGITS-1:0]   = blink_r;
        if (sel_period) rd_data[CNT_W-1:0]     = period_r;
    end

    // Release the bus whenever this device is not being read.
    assign dbus = rd_en ? rd_data : {DBITS{1'bz}};

    // BLANK wins over BLINK; a blinking digit is dark while phase is low.
    for (genvar i = 0; i < NDIGITS; i++) begin : g_digit
        logic [6:0] glyph;
        seg7_decode u_dec (
            .nibble (data_r[4*i +: 4]),
            .seg    (glyph)
        );
        assign hex_next[7*i +: 7] = (blank_r[i] || (blink_r[i] && !phase)) ? SEG_BLANK : glyph;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_r   <= '0;
            blank_r  <= '0;
            blink_r  <= '0;
            period_r <= CNT_W'(BLINK_DEFAULT);
            cnt      <= '0;
            phase    <= 1'b1;
            hex_out  <= {NDIGITS{7'b1000000}};
        end else begin
            if (bus.wrtEn && sel_data)   data_r   <= dbus[4*NDIGITS-1:0];
            if (bus.wrtEn && sel_blank)  blank_r  <= dbus[NDIGITS-1:0];
            if (bus.wrtEn && sel_blink)  blink_r  <= dbus[NDIGITS-1:0];
            if (bus.wrtEn && sel_period) period_r <= dbus[CNT_W-1:0];

            // A new period restarts the blink cycle in the visible half.
            if ((bus.wrtEn && sel_period) || period_r == '0) begin
                cnt   <= '0;
                phase <= 1'b1;
            end else if (cnt == period_r - CNT_W'(1)) begin
                cnt   <= '0;
                phase <= ~phase;
            end else begin
                cnt   <= cnt + CNT_W'(1);
            end

            hex_out <= hex_next;
        end
    end

endmodule
